// File: rtl/trig_watchdog_mc.sv
// Multi-channel trigger watchdog: each channel arms on its first active-low trigger and
// expires when the trigger stays inactive past a programmable interval.
module trig_watchdog_mc #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned TIMEOUT     = 50000000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_PULSE   = 16,
  parameter bit          STICKY_RST  = 1'b0
) (
  input  logic              sys_clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] trig_b_i,
  input  logic [NUM_CH-1:0] ch_enable_i,
  input  logic [CNT_W-1:0]  timeout_i,
  input  logic              clear_i,
  output logic [NUM_CH-1:0] armed_o,
  output logic [NUM_CH-1:0] timeout_o,
  output logic              wd_rst_o
);

  localparam int unsigned PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  typedef enum logic [1:0] {StIdle, StArmed, StExpired} state_e;

  logic [NUM_CH-1:0] w_expire;
  logic              w_any_expire;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    state_e                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_armed;
    logic                   r_tmo;
    logic                   w_active;

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_sync <= '1;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], trig_b_i[g]};
      end
    end

    assign w_active = ~r_sync[SYNC_STAGES-1];

    // A clear or disable in the same cycle swallows the expiry entirely.
    assign w_expire[g] = (r_state == StArmed) && ch_enable_i[g] && !clear_i &&
                         !w_active && (r_cnt == '0);

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_state <= StIdle;
        r_cnt   <= CNT_W'(TIMEOUT);
        r_armed <= 1'b0;
        r_tmo   <= 1'b0;
      end else if (clear_i) begin
        r_state <= StIdle;
        r_cnt   <= timeout_i;
        r_armed <= 1'b0;
        r_tmo   <= 1'b0;
      end else if (!ch_enable_i[g]) begin
        r_state <= StIdle;
        r_cnt   <= timeout_i;
        r_armed <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            r_cnt <= timeout_i;
            if (w_active) begin
              r_state <= StArmed;
              r_armed <= 1'b1;
            end
          end
          StArmed: begin
            if (w_active) begin
              r_cnt <= timeout_i;
            end else if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end else begin
              r_state <= StExpired;
              r_armed <= 1'b0;
              r_tmo   <= 1'b1;
            end
          end
          StExpired: begin
            r_state <= StExpired;
          end
          default: begin
            r_state <= StIdle;
            r_armed <= 1'b0;
          end
        endcase
      end
    end

    assign armed_o[g]   = r_armed;
    assign timeout_o[g] = r_tmo;
  end

  assign w_any_expire = |w_expire;

  logic          r_wd;
  logic [PW-1:0] r_pcnt;

  // Pulse mode ignores events while the pulse is running; it is never extended.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd   <= 1'b0;
      r_pcnt <= '0;
    end else if (STICKY_RST) begin
      if (w_any_expire) begin
        r_wd <= 1'b1;
      end
    end else if (!r_wd) begin
      if (w_any_expire) begin
        r_wd   <= 1'b1;
        r_pcnt <= PW'(RST_PULSE - 1);
      end
    end else if (r_pcnt == '0) begin
      r_wd <= 1'b0;
    end else begin
      r_pcnt <= r_pcnt - PW'(1);
    end
  end

  assign wd_rst_o = r_wd;

endmodule

// File: tb/tb_trig_watchdog_mc.sv
// Bench for trig_watchdog_mc: a deadline-based reference model checked every cycle against a
// pulse-mode and a sticky-mode instance, plus hand-computed edge expectations.
module tb_trig_watchdog_mc;

  localparam int NCH = 2;
  localparam int S   = 2;
  localparam int P   = 16;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic [1:0]  trig_b;
  logic [1:0]  en;
  logic [25:0] tmo_in;
  logic        clr;
  logic [1:0]  armed_p, tmo_p, armed_s, tmo_s;
  logic        wd_p, wd_s;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  trig_watchdog_mc #(
    .NUM_CH(2), .CNT_W(26), .TIMEOUT(50000000), .SYNC_STAGES(2), .RST_PULSE(16),
    .STICKY_RST(1'b0)
  ) u_dut_pulse (
    .sys_clk_i(sys_clk), .rst_i(rst), .trig_b_i(trig_b), .ch_enable_i(en),
    .timeout_i(tmo_in), .clear_i(clr), .armed_o(armed_p), .timeout_o(tmo_p),
    .wd_rst_o(wd_p)
  );

  trig_watchdog_mc #(
    .NUM_CH(2), .CNT_W(26), .TIMEOUT(50000000), .SYNC_STAGES(2), .RST_PULSE(16),
    .STICKY_RST(1'b1)
  ) u_dut_sticky (
    .sys_clk_i(sys_clk), .rst_i(rst), .trig_b_i(trig_b), .ch_enable_i(en),
    .timeout_i(tmo_in), .clear_i(clr), .armed_o(armed_s), .timeout_o(tmo_s),
    .wd_rst_o(wd_s)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 armed, 2 expired; an armed channel expires on the first
  // inactive edge at or beyond last_active_edge + T + 1.
  logic [1:0] q_sync[$];
  int         m_mode[NCH];
  longint     m_dead[NCH];
  logic [1:0] m_tmo;
  logic       m_wd_p, m_wd_s;
  longint     m_pend;
  longint     n = 0;
  logic [1:0] seen;
  logic [1:0] exp_armed;
  bit         ev;
  bit         act;

  always @(posedge sys_clk) begin
    n++;
    if (rst) begin
      q_sync.delete();
      for (int i = 0; i < S; i++) q_sync.push_back(2'b11);
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0;
        m_dead[c] = 0;
      end
      m_tmo  = 2'b00;
      m_wd_p = 1'b0;
      m_wd_s = 1'b0;
      m_pend = 0;
    end else begin
      seen = q_sync.pop_front();
      q_sync.push_back(trig_b);
      ev = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        act = !seen[c];
        if (clr) begin
          m_mode[c] = 0;
          m_tmo[c]  = 1'b0;
        end else if (!en[c]) begin
          m_mode[c] = 0;
        end else if (m_mode[c] == 0) begin
          if (act) begin
            m_mode[c] = 1;
            m_dead[c] = n + longint'(tmo_in) + 1;
          end
        end else if (m_mode[c] == 1) begin
          if (act) begin
            m_dead[c] = n + longint'(tmo_in) + 1;
          end else if (n >= m_dead[c]) begin
            m_mode[c] = 2;
            m_tmo[c]  = 1'b1;
            ev        = 1'b1;
          end
        end
      end
      if (ev && !m_wd_p) m_pend = n + P;
      m_wd_p = (n < m_pend);
      if (ev) m_wd_s = 1'b1;
    end
    #2;
    if (!rst) begin
      for (int c = 0; c < NCH; c++) exp_armed[c] = (m_mode[c] == 1);
      chk("m_armed_p", 32'(armed_p), 32'(exp_armed));
      chk("m_armed_s", 32'(armed_s), 32'(exp_armed));
      chk("m_tmo_p", 32'(tmo_p), 32'(m_tmo));
      chk("m_tmo_s", 32'(tmo_s), 32'(m_tmo));
      chk("m_wd_p", 32'(wd_p), 32'(m_wd_p));
      chk("m_wd_s", 32'(wd_s), 32'(m_wd_s));
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_tmo(input string nm, input logic [1:0] mask, input int budget);
    int k = 0;
    while (((tmo_p & mask) != mask) && (k < budget)) begin
      tick(1);
      k++;
    end
    chk(nm, 32'(tmo_p & mask), 32'(mask));
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  int hi;

  initial begin
    rst    = 1'b1;
    trig_b = 2'b11;
    en     = 2'b00;
    tmo_in = 26'd5;
    clr    = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("rst_armed", 32'(armed_p), 32'd0);
    chk("rst_tmo", 32'(tmo_p), 32'd0);
    chk("rst_wd", 32'(wd_p | wd_s), 32'd0);

    // Enabled but never triggered: must never expire.
    en = 2'b11;
    tick(1000);
    chk("idle_tmo", 32'(tmo_p | tmo_s), 32'd0);
    chk("idle_wd", 32'(wd_p | wd_s), 32'd0);

    // Single expiry: raw low at edges 0..4, T=10.
    en     = 2'b01;
    tmo_in = 26'd10;
    trig_b = 2'b10;
    for (int e = 0; e <= 40; e++) begin
      tick(1);
      if (e == 1) chk("arm_e1", 32'(armed_p[0]), 32'd0);
      if (e == 2) chk("arm_e2", 32'(armed_p[0]), 32'd1);
      if (e == 16) chk("exp_e16", 32'({tmo_p, wd_p}), 32'b000);
      if (e == 17) begin
        chk("exp_e17_tmo", 32'(tmo_p), 32'b01);
        chk("exp_e17_wd", 32'({wd_p, wd_s}), 32'b11);
        chk("exp_e17_arm", 32'(armed_p), 32'd0);
      end
      if (e == 32) chk("pulse_e32", 32'(wd_p), 32'd1);
      if (e == 33) chk("pulse_e33", 32'(wd_p), 32'd0);
      if (e == 40) chk("sticky_e40", 32'(wd_s), 32'd1);
      if (e == 4) trig_b = 2'b11;
    end
    en = 2'b00;
    tick(2);
    chk("dis_keeps_tmo", 32'(tmo_p), 32'b01);
    pulse_clear();
    chk("clear_tmo", 32'(tmo_p), 32'd0);
    chk("clear_keeps_sticky", 32'(wd_s), 32'd1);
    tick(1);

    // Keep-alive: period 11 survives T=10, period 12 does not.
    en = 2'b01;
    for (int i = 0; i < 200; i++) begin
      trig_b = (i % 11 == 0) ? 2'b10 : 2'b11;
      tick(1);
    end
    chk("keep11_tmo", 32'(tmo_p), 32'd0);
    chk("keep11_arm", 32'(armed_p), 32'b01);
    for (int i = 0; i < 48; i++) begin
      trig_b = (i % 12 == 0) ? 2'b10 : 2'b11;
      tick(1);
    end
    trig_b = 2'b11;
    chk("keep12_tmo", 32'(tmo_p), 32'b01);
    pulse_clear();
    tick(20);

    // Simultaneous expiry, then ch1 re-expires mid-pulse.
    en     = 2'b11;
    tmo_in = 26'd8;
    trig_b = 2'b00;
    tick(1);
    trig_b = 2'b11;
    wait_tmo("simul_wait", 2'b11, 30);
    chk("simul_wd", 32'(wd_p), 32'd1);
    hi = 1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 1) en = 2'b01;
      if (i == 2) begin
        en     = 2'b11;
        trig_b = 2'b01;
        tmo_in = 26'd2;
      end
      if (i == 3) trig_b = 2'b11;
      tick(1);
      hi += int'(wd_p);
    end
    chk("one_pulse_len", 32'(hi), 32'd16);
    chk("overlap_tmo", 32'(tmo_p), 32'b11);
    pulse_clear();
    tick(1);

    // Clear on the expiry edge (armed at edge 2, would expire at edge 7).
    en     = 2'b11;
    tmo_in = 26'd4;
    for (int e = 0; e <= 12; e++) begin
      if (e == 0) trig_b = 2'b00;
      if (e == 1) trig_b = 2'b11;
      if (e == 7) clr = 1'b1;
      if (e == 8) clr = 1'b0;
      tick(1);
      if (e == 6) chk("clr_pre_arm", 32'(armed_p), 32'b11);
      if (e == 7) chk("clr_edge", 32'({armed_p, tmo_p}), 32'd0);
      if (e == 12) chk("clr_after", 32'({armed_p, tmo_p, wd_p}), 32'd0);
    end

    // Disable while expired and while armed; timeout_o is held.
    en     = 2'b01;
    tmo_in = 26'd3;
    trig_b = 2'b10;
    tick(1);
    trig_b = 2'b11;
    wait_tmo("dis_wait", 2'b01, 20);
    en = 2'b00;
    tick(1);
    chk("dis_exp_tmo", 32'(tmo_p), 32'b01);
    en     = 2'b01;
    trig_b = 2'b10;
    tick(1);
    trig_b = 2'b11;
    tick(2);
    chk("rearm", 32'(armed_p), 32'b01);
    en = 2'b00;
    tick(1);
    chk("dis_armed_arm", 32'(armed_p), 32'd0);
    chk("dis_armed_tmo", 32'(tmo_p), 32'b01);
    en = 2'b01;
    tick(10);
    chk("reen_idle", 32'(armed_p), 32'd0);

    // T=0: expiry on the first inactive edge after the last active one.
    pulse_clear();
    tick(20);
    tmo_in = 26'd0;
    trig_b = 2'b10;
    tick(1);
    trig_b = 2'b11;
    tick(2);
    chk("t0_arm", 32'({armed_p, tmo_p}), 32'b0100);
    tick(1);
    chk("t0_exp", 32'({armed_p, tmo_p}), 32'b0001);

    // Asynchronous reset mid-pulse drops both watchdog outputs at once.
    tick(3);
    chk("pre_rst_wd", 32'({wd_p, wd_s}), 32'b11);
    rst = 1'b1;
    #1;
    chk("async_wd", 32'({wd_p, wd_s}), 32'd0);
    chk("async_out", 32'({armed_p, tmo_p, armed_s, tmo_s}), 32'd0);
    tick(3);
    rst = 1'b0;
    en  = 2'b00;
    tick(20);
    chk("post_rst", 32'({armed_p, tmo_p, wd_p, wd_s}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
